// File: rtl/fog_loop_seq.sv
// FOG loop acquisition sequencer: settle, coarse acquisition, fine tracking, lock and relock.
// Optional COARSE timeout back to SETTLE is compiled in with FOG_SEQ_TIMEOUT_EN.
module fog_loop_seq #(
  parameter int CNT_W    = 16,
  parameter int RELOCK_W = 16,
  parameter int ERR_W    = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic                i_trig,
  input  logic [ERR_W-1:0]    i_err,
  input  logic [CNT_W-1:0]    i_settle_cnt,
  input  logic [ERR_W-1:0]    i_lock_thr,
  input  logic [CNT_W-1:0]    i_lock_cnt,
  input  logic [CNT_W-1:0]    i_unlock_cnt,
  input  logic [CNT_W-1:0]    i_timeout_cnt,
  input  logic [31:0]         i_gain_step_coarse,
  input  logic [31:0]         i_gain_step_fine,
  input  logic [31:0]         i_gain_ramp_coarse,
  input  logic [31:0]         i_gain_ramp_fine,
  output logic                o_fb_ON,
  output logic [31:0]         o_gainSel_step,
  output logic [31:0]         o_gainSel_ramp,
  output logic [2:0]          o_state,
  output logic                o_locked,
  output logic [RELOCK_W-1:0] o_relock_cnt,
  output logic                o_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_COARSE = 3'd2,
    ST_FINE   = 3'd3,
    ST_LOCKED = 3'd4
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};
  localparam logic [ERR_W-1:0] ERR_MAX = {1'b0, {(ERR_W-1){1'b1}}};

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    ok_cnt, bad_cnt, per_cnt;
  logic [CNT_W-1:0]    ok_upd, bad_upd, per_upd;
  logic [CNT_W-1:0]    lock_eff, unlock_eff;
  logic [RELOCK_W-1:0] relock_cnt;
  logic [ERR_W-1:0]    mag;
  logic                err_in;
  logic                per_en;
  logic                relock_inc;
  logic                timeout_nxt;
  logic                fb_nxt, locked_nxt, fine_nxt;

  // Most negative error has no positive twin, so it clamps to the largest magnitude.
  always_comb begin
    mag = i_err;
    if (i_err == ERR_MIN) begin
      mag = ERR_MAX;
    end else if (i_err[ERR_W-1]) begin
      mag = -i_err;
    end
    err_in = (mag < i_lock_thr);
  end

  assign lock_eff   = (i_lock_cnt   == '0) ? CNT_W'(1) : i_lock_cnt;
  assign unlock_eff = (i_unlock_cnt == '0) ? CNT_W'(1) : i_unlock_cnt;

`ifdef FOG_SEQ_TIMEOUT_EN
  assign per_en = (state == ST_SETTLE) || (state == ST_COARSE);
`else
  assign per_en = (state == ST_SETTLE);
  logic unused_timeout_cnt;
  assign unused_timeout_cnt = ^i_timeout_cnt;
`endif

  // Counter values as they will be after this cycle's trig, used for the transition decisions.
  always_comb begin
    ok_upd  = ok_cnt;
    bad_upd = bad_cnt;
    per_upd = per_cnt;
    if (i_trig) begin
      if (err_in) begin
        ok_upd  = (ok_cnt == '1) ? ok_cnt : ok_cnt + CNT_W'(1);
        bad_upd = '0;
      end else begin
        bad_upd = (bad_cnt == '1) ? bad_cnt : bad_cnt + CNT_W'(1);
        ok_upd  = '0;
      end
      if (per_en) begin
        per_upd = (per_cnt == '1) ? per_cnt : per_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    relock_inc  = 1'b0;
    timeout_nxt = 1'b0;
    if ((state != ST_IDLE) && !i_enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_enable) state_nxt = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (per_upd >= i_settle_cnt) state_nxt = ST_COARSE;
        end
        ST_COARSE: begin
          if (i_trig && (ok_upd >= lock_eff)) begin
            state_nxt = ST_FINE;
          end
`ifdef FOG_SEQ_TIMEOUT_EN
          else if ((i_timeout_cnt != '0) && (per_upd >= i_timeout_cnt)) begin
            state_nxt   = ST_SETTLE;
            timeout_nxt = 1'b1;
          end
`endif
        end
        ST_FINE: begin
          if (i_trig && (ok_upd >= lock_eff)) begin
            state_nxt = ST_LOCKED;
          end else if (i_trig && (bad_upd >= unlock_eff)) begin
            state_nxt = ST_COARSE;
          end
        end
        ST_LOCKED: begin
          if (i_trig && (bad_upd >= unlock_eff)) begin
            state_nxt  = ST_COARSE;
            relock_inc = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs decode from the next state so they register on the same edge as the state.
  always_comb begin
    fb_nxt     = (state_nxt == ST_COARSE) || (state_nxt == ST_FINE) || (state_nxt == ST_LOCKED);
    fine_nxt   = (state_nxt == ST_FINE) || (state_nxt == ST_LOCKED);
    locked_nxt = (state_nxt == ST_LOCKED);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= ST_IDLE;
      ok_cnt         <= '0;
      bad_cnt        <= '0;
      per_cnt        <= '0;
      relock_cnt     <= '0;
      o_fb_ON        <= 1'b0;
      o_locked       <= 1'b0;
      o_timeout      <= 1'b0;
      o_gainSel_step <= '0;
      o_gainSel_ramp <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        ok_cnt  <= '0;
        bad_cnt <= '0;
        per_cnt <= '0;
      end else begin
        ok_cnt  <= ok_upd;
        bad_cnt <= bad_upd;
        per_cnt <= per_upd;
      end
      if (relock_inc && (relock_cnt != '1)) begin
        relock_cnt <= relock_cnt + RELOCK_W'(1);
      end
      o_fb_ON        <= fb_nxt;
      o_locked       <= locked_nxt;
      o_timeout      <= timeout_nxt;
      o_gainSel_step <= fine_nxt ? i_gain_step_fine : i_gain_step_coarse;
      o_gainSel_ramp <= fine_nxt ? i_gain_ramp_fine : i_gain_ramp_coarse;
    end
  end

  assign o_state      = state;
  assign o_relock_cnt = relock_cnt;

endmodule

// File: tb/tb_fog_loop_seq.sv
// Self-checking bench for fog_loop_seq: directed acquisition scenarios plus a per-cycle reference model.
// Build with FOG_SEQ_TIMEOUT_EN defined to exercise the COARSE timeout path.
module tb_fog_loop_seq;

`ifdef FOG_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam longint SAT = 65535;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_trig = 1'b0;
  logic [31:0] i_err = '0;
  logic [15:0] i_settle_cnt = 16'd4;
  logic [31:0] i_lock_thr = 32'd100;
  logic [15:0] i_lock_cnt = 16'd3;
  logic [15:0] i_unlock_cnt = 16'd2;
  logic [15:0] i_timeout_cnt = 16'd0;
  logic [31:0] i_gain_step_coarse = 32'h11;
  logic [31:0] i_gain_step_fine = 32'h22;
  logic [31:0] i_gain_ramp_coarse = 32'h33;
  logic [31:0] i_gain_ramp_fine = 32'h44;
  logic        o_fb_ON;
  logic [31:0] o_gainSel_step;
  logic [31:0] o_gainSel_ramp;
  logic [2:0]  o_state;
  logic        o_locked;
  logic [15:0] o_relock_cnt;
  logic        o_timeout;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  fog_loop_seq dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_trig(i_trig), .i_err(i_err),
    .i_settle_cnt(i_settle_cnt), .i_lock_thr(i_lock_thr), .i_lock_cnt(i_lock_cnt),
    .i_unlock_cnt(i_unlock_cnt), .i_timeout_cnt(i_timeout_cnt),
    .i_gain_step_coarse(i_gain_step_coarse), .i_gain_step_fine(i_gain_step_fine),
    .i_gain_ramp_coarse(i_gain_ramp_coarse), .i_gain_ramp_fine(i_gain_ramp_fine),
    .o_fb_ON(o_fb_ON), .o_gainSel_step(o_gainSel_step), .o_gainSel_ramp(o_gainSel_ramp),
    .o_state(o_state), .o_locked(o_locked), .o_relock_cnt(o_relock_cnt), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  // Reference model: states as plain integers 0..4, counters as wide integers clamped at 65535.
  int     m_st = 0;
  longint m_ok = 0, m_bad = 0, m_per = 0, m_relock = 0;
  bit     m_fb = 0, m_locked = 0, m_to = 0;
  logic [31:0] m_step = '0, m_ramp = '0;

  always @(posedge clk) begin : model
    longint e, mag, lk, ul, nok, nbad, nper;
    int nst;
    bit inr, tmo, rel, fine;
    if (i_rst) begin
      m_st <= 0; m_ok <= 0; m_bad <= 0; m_per <= 0; m_relock <= 0;
      m_fb <= 0; m_locked <= 0; m_to <= 0; m_step <= '0; m_ramp <= '0;
    end else begin
      e = longint'($signed(i_err));
      mag = (e < 0) ? -e : e;
      if (mag > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
      inr = mag < longint'(i_lock_thr);
      lk = (i_lock_cnt == 0) ? 1 : longint'(i_lock_cnt);
      ul = (i_unlock_cnt == 0) ? 1 : longint'(i_unlock_cnt);
      nok = m_ok; nbad = m_bad; nper = m_per;
      if (i_trig) begin
        nok  = inr ? ((m_ok + 1 > SAT) ? SAT : m_ok + 1) : 0;
        nbad = inr ? 0 : ((m_bad + 1 > SAT) ? SAT : m_bad + 1);
        if (m_st == 1 || (TO_EN && m_st == 2)) nper = (m_per + 1 > SAT) ? SAT : m_per + 1;
      end
      nst = m_st; tmo = 0; rel = 0;
      if (m_st != 0 && !i_enable) nst = 0;
      else if (m_st == 0) begin
        if (i_enable) nst = 1;
      end else if (m_st == 1) begin
        if (nper >= longint'(i_settle_cnt)) nst = 2;
      end else if (m_st == 2) begin
        if (i_trig && nok >= lk) nst = 3;
        else if (TO_EN && i_timeout_cnt != 0 && nper >= longint'(i_timeout_cnt)) begin
          nst = 1; tmo = 1;
        end
      end else if (m_st == 3) begin
        if (i_trig && nok >= lk) nst = 4;
        else if (i_trig && nbad >= ul) nst = 2;
      end else if (m_st == 4) begin
        if (i_trig && nbad >= ul) begin nst = 2; rel = 1; end
      end
      fine = (nst == 3 || nst == 4);
      m_st     <= nst;
      m_ok     <= (nst != m_st) ? 0 : nok;
      m_bad    <= (nst != m_st) ? 0 : nbad;
      m_per    <= (nst != m_st) ? 0 : nper;
      m_relock <= (rel && m_relock < SAT) ? m_relock + 1 : m_relock;
      m_fb     <= (nst >= 2);
      m_locked <= (nst == 4);
      m_to     <= tmo;
      m_step   <= fine ? i_gain_step_fine : i_gain_step_coarse;
      m_ramp   <= fine ? i_gain_ramp_fine : i_gain_ramp_coarse;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_state", 32'(o_state), 32'(m_st));
      checkOutput("model_fb", 32'(o_fb_ON), 32'(m_fb));
      checkOutput("model_locked", 32'(o_locked), 32'(m_locked));
      checkOutput("model_timeout", 32'(o_timeout), 32'(m_to));
      checkOutput("model_relock", 32'(o_relock_cnt), 32'(m_relock));
      checkOutput("model_step", o_gainSel_step, m_step);
      checkOutput("model_ramp", o_gainSel_ramp, m_ramp);
    end
  end

  // One modulation period: nine quiet cycles, then a trig carrying the error sample.
  task automatic applyStimulus(input logic [31:0] err);
    repeat (9) @(negedge clk);
    i_trig = 1'b1;
    i_err  = err;
    @(negedge clk);
    i_trig = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    checkOutput("rst_state", 32'(o_state), 32'd0);
    checkOutput("rst_fb", 32'(o_fb_ON), 32'd0);
    checkOutput("rst_step", o_gainSel_step, 32'd0);
    checkOutput("rst_relock", 32'(o_relock_cnt), 32'd0);

    i_rst = 1'b0;
    i_enable = 1'b1;
    @(negedge clk);
    checkOutput("settle_state", 32'(o_state), 32'd1);
    checkOutput("settle_step", o_gainSel_step, 32'h11);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(32'd1000);
      checkOutput("settle_fb_off", 32'(o_fb_ON), 32'd0);
    end
    applyStimulus(32'd1000);
    checkOutput("coarse_state", 32'(o_state), 32'd2);
    checkOutput("coarse_fb", 32'(o_fb_ON), 32'd1);
    checkOutput("coarse_step", o_gainSel_step, 32'h11);

    applyStimulus(32'd50);
    applyStimulus(-32'sd50);
    applyStimulus(32'd200);
    applyStimulus(32'd10);
    applyStimulus(32'd20);
    checkOutput("coarse_hold", 32'(o_state), 32'd2);
    applyStimulus(-32'sd99);
    checkOutput("fine_state", 32'(o_state), 32'd3);
    checkOutput("fine_step", o_gainSel_step, 32'h22);
    checkOutput("fine_ramp", o_gainSel_ramp, 32'h44);
    applyStimulus(32'd1);
    applyStimulus(32'd2);
    applyStimulus(32'd3);
    checkOutput("locked_state", 32'(o_state), 32'd4);
    checkOutput("locked_flag", 32'(o_locked), 32'd1);

    i_gain_step_fine = 32'h55;
    @(negedge clk);
    checkOutput("live_gain", o_gainSel_step, 32'h55);

    applyStimulus(32'd500);
    applyStimulus(32'd5);
    applyStimulus(32'd500);
    checkOutput("locked_hold", 32'(o_state), 32'd4);
    applyStimulus(32'd500);
    checkOutput("relock_state", 32'(o_state), 32'd2);
    checkOutput("relock_cnt1", 32'(o_relock_cnt), 32'd1);
    checkOutput("relock_unlocked", 32'(o_locked), 32'd0);

    i_lock_cnt = 16'd1;
    i_lock_thr = 32'h7FFF_FFFF;
    applyStimulus(32'h8000_0000);
    checkOutput("minneg_out", 32'(o_state), 32'd2);
    i_lock_thr = 32'd100;
    applyStimulus(-32'sd99);
    checkOutput("neg99_in", 32'(o_state), 32'd3);

    i_enable = 1'b0;
    @(negedge clk);
    checkOutput("disable_state", 32'(o_state), 32'd0);
    checkOutput("disable_fb", 32'(o_fb_ON), 32'd0);
    checkOutput("disable_relock", 32'(o_relock_cnt), 32'd1);

    i_settle_cnt = 16'd0;
    i_lock_cnt = 16'd0;
    i_enable = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("settle0_state", 32'(o_state), 32'd2);
    applyStimulus(32'd5);
    applyStimulus(32'd5);
    checkOutput("lock0_state", 32'(o_state), 32'd4);
    i_unlock_cnt = 16'd0;
    applyStimulus(32'd500);
    checkOutput("unlock0_state", 32'(o_state), 32'd2);
    checkOutput("relock_cnt2", 32'(o_relock_cnt), 32'd2);
    i_lock_cnt = 16'd1;
    applyStimulus(32'd5);
    applyStimulus(32'd5);

    i_rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_state", 32'(o_state), 32'd0);
    checkOutput("rst_mid_relock", 32'(o_relock_cnt), 32'd0);
    checkOutput("rst_mid_step", o_gainSel_step, 32'd0);
    i_rst = 1'b0;
    i_timeout_cnt = 16'd5;
    i_unlock_cnt = 16'd2;
    repeat (2) @(negedge clk);
    checkOutput("to_coarse", 32'(o_state), 32'd2);
    for (int k = 0; k < 4; k++) applyStimulus(32'd500);
    checkOutput("to_hold", 32'(o_state), 32'd2);
    applyStimulus(32'd500);
    checkOutput("to_state", 32'(o_state), TO_EN ? 32'd1 : 32'd2);
    checkOutput("to_pulse", 32'(o_timeout), TO_EN ? 32'd1 : 32'd0);
    checkOutput("to_fb", 32'(o_fb_ON), TO_EN ? 32'd0 : 32'd1);
    @(negedge clk);
    checkOutput("to_pulse_end", 32'(o_timeout), 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
